// File: rtl/loop_nest_sequencer_pkg.sv
// Shared definitions for the loop nest sequencer.
//   seq_state_t          : sequencer FSM state (IDLE / RUN / DONE), 2-bit
//   DEFAULT_WIDTH_COUNT  : default width of loop bounds and indices
//   state_is_busy()      : true in the states that report O_Busy
package loop_nest_sequencer_pkg;

  localparam int unsigned DEFAULT_WIDTH_COUNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_state_t;

  function automatic logic state_is_busy(input seq_state_t s);
    return (s == ST_RUN) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/loop_nest_sequencer_loop_level_counter.sv
// One level of the loop nest: an index register with a registered terminal
// value (bound - 1) captured at load time.
//   clock, reset : system clock, synchronous active-high reset
//   I_Clear      : force the index to zero (highest priority after reset)
//   I_Load       : capture I_Bound - 1 as the terminal value, clear index
//   I_Bound      : iteration count for this level
//   I_Enable     : advance the index; wraps to zero at the terminal value
//   O_Index      : current index
//   O_Term       : index equals the terminal value
module loop_level_counter
  import loop_nest_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_COUNT = DEFAULT_WIDTH_COUNT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Clear,
  input  logic                   I_Load,
  input  logic [WIDTH_COUNT-1:0] I_Bound,
  input  logic                   I_Enable,
  output logic [WIDTH_COUNT-1:0] O_Index,
  output logic                   O_Term
);

  typedef logic [WIDTH_COUNT-1:0] count_t;

  count_t index_q;
  count_t term_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      index_q <= '0;
      term_q  <= '0;
    end else begin
      if (I_Load) begin
        term_q <= I_Bound - count_t'(1);
      end
      if (I_Clear || I_Load) begin
        index_q <= '0;
      end else if (I_Enable) begin
        // Wrap at the terminal value so the index never passes bound - 1.
        index_q <= O_Term ? '0 : index_q + count_t'(1);
      end
    end
  end

  assign O_Index = index_q;
  assign O_Term  = (index_q == term_q);

endmodule

// File: rtl/loop_nest_sequencer.sv
// Two-level loop sequencer: emits one (outer, inner) index pair per beat on
// a valid/ready stream, inner index fastest, and pulses O_Done after the
// final beat.
//   clock, reset                 : system clock, synchronous active-high reset
//   I_Start                      : launch a nest (sampled in IDLE only)
//   I_Abort                      : end the current run without O_Done
//   I_Inner_Bound, I_Outer_Bound : iteration counts, latched at start
//   I_Ready                      : consumer accepts the current beat
//   O_Valid, O_Inner, O_Outer    : beat and its index pair
//   O_Last                       : current beat is the final one of the nest
//   O_Busy                       : high in RUN and DONE
//   O_Done                       : one-cycle completion pulse
module loop_nest_sequencer
  import loop_nest_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH_COUNT = DEFAULT_WIDTH_COUNT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Start,
  input  logic                   I_Abort,
  input  logic [WIDTH_COUNT-1:0] I_Inner_Bound,
  input  logic [WIDTH_COUNT-1:0] I_Outer_Bound,
  input  logic                   I_Ready,
  output logic                   O_Valid,
  output logic [WIDTH_COUNT-1:0] O_Inner,
  output logic [WIDTH_COUNT-1:0] O_Outer,
  output logic                   O_Last,
  output logic                   O_Busy,
  output logic                   O_Done
);

  seq_state_t state_q;
  seq_state_t state_next;

  logic start_go;
  logic zero_bound;
  logic transfer;
  logic level_clear;
  logic inner_term;
  logic outer_term;

  // Abort in IDLE suppresses a coincident start.
  assign start_go    = (state_q == ST_IDLE) && I_Start && !I_Abort;
  assign zero_bound  = (I_Inner_Bound == '0) || (I_Outer_Bound == '0);
  assign transfer    = O_Valid && I_Ready;
  // Indices sit at zero whenever no run is active, and an abort clears them
  // even if it coincides with a transfer.
  assign level_clear = (state_q != ST_RUN) || I_Abort;

  loop_level_counter #(
    .WIDTH_COUNT (WIDTH_COUNT)
  ) u_inner (
    .clock    (clock),
    .reset    (reset),
    .I_Clear  (level_clear),
    .I_Load   (start_go),
    .I_Bound  (I_Inner_Bound),
    .I_Enable (transfer),
    .O_Index  (O_Inner),
    .O_Term   (inner_term)
  );

  loop_level_counter #(
    .WIDTH_COUNT (WIDTH_COUNT)
  ) u_outer (
    .clock    (clock),
    .reset    (reset),
    .I_Clear  (level_clear),
    .I_Load   (start_go),
    .I_Bound  (I_Outer_Bound),
    .I_Enable (transfer && inner_term),
    .O_Index  (O_Outer),
    .O_Term   (outer_term)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_go) begin
          state_next = zero_bound ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (I_Abort) begin
          state_next = ST_IDLE;
        end else if (transfer && inner_term && outer_term) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    O_Valid = 1'b0;
    O_Done  = 1'b0;
    O_Busy  = state_is_busy(state_q);
    unique case (state_q)
      ST_RUN:  O_Valid = 1'b1;
      // An abort landing on the DONE cycle cancels the completion pulse.
      ST_DONE: O_Done  = !I_Abort;
      default: ;
    endcase
  end

  assign O_Last = O_Valid && inner_term && outer_term;

endmodule

// File: tb/tb_loop_nest_sequencer.sv
module tb_loop_nest_sequencer;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic         I_Start;
  logic         I_Abort;
  logic [W-1:0] I_Inner_Bound;
  logic [W-1:0] I_Outer_Bound;
  logic         I_Ready;
  logic         O_Valid;
  logic [W-1:0] O_Inner;
  logic [W-1:0] O_Outer;
  logic         O_Last;
  logic         O_Busy;
  logic         O_Done;

  loop_nest_sequencer #(.WIDTH_COUNT(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .I_Start       (I_Start),
    .I_Abort       (I_Abort),
    .I_Inner_Bound (I_Inner_Bound),
    .I_Outer_Bound (I_Outer_Bound),
    .I_Ready       (I_Ready),
    .O_Valid       (O_Valid),
    .O_Inner       (O_Inner),
    .O_Outer       (O_Outer),
    .O_Last        (O_Last),
    .O_Busy        (O_Busy),
    .O_Done        (O_Done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int rmode = 0;  // 0: ready high, 1: low on odd cycles, 2: random

  // Model: the list of beats still owed, plus a pending completion pulse.
  int unsigned q[$];
  bit          m_done = 1'b0;

  // Log of what the DUT actually delivered.
  int unsigned cap[$];
  int          cap_cyc[$];
  int          done_cnt;
  int          done_cyc;
  int          last_cyc;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic clear_log();
    cap.delete();
    cap_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_cyc = -1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Model update on each active edge from the inputs sampled there.
  initial forever begin
    @(posedge clock);
    cyc++;
    if (reset) begin
      q.delete();
      m_done = 1'b0;
    end else if (I_Abort) begin
      q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (q.size() != 0) begin
      if (I_Ready) begin
        void'(q.pop_front());
        if (q.size() == 0) m_done = 1'b1;
      end
    end else if (I_Start) begin
      if (I_Inner_Bound == 0 || I_Outer_Bound == 0) begin
        m_done = 1'b1;
      end else begin
        for (int unsigned o = 0; o < I_Outer_Bound; o++)
          for (int unsigned i = 0; i < I_Inner_Bound; i++)
            q.push_back((o << 8) | i);
      end
    end
  end

  // Per-cycle compare against the model, plus delivery logging.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      bit          ev;
      int unsigned head;
      ev   = (q.size() != 0);
      head = ev ? q[0] : 0;
      chk("valid", O_Valid, ev);
      chk("outer", O_Outer, head >> 8);
      chk("inner", O_Inner, head & 8'hFF);
      chk("last",  O_Last,  ev && (q.size() == 1));
      chk("busy",  O_Busy,  ev || m_done);
      chk("done",  O_Done,  m_done && !I_Abort);
      if (!reset && O_Valid && I_Ready) begin
        cap.push_back({O_Outer, O_Inner});
        cap_cyc.push_back(cyc);
      end
      if (!reset && O_Last) last_cyc = cyc;
      if (O_Done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  initial forever begin
    @(posedge clock);
    #1;
    case (rmode)
      0:       I_Ready = 1'b1;
      1:       I_Ready = (cyc % 2) == 0;
      default: I_Ready = ($urandom % 10) < 7;
    endcase
  end

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      step();
      if (!O_Busy) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  // Returns the cycle on which the start was sampled.
  task automatic launch(input int ib, input int ob, output int s);
    I_Start       = 1'b1;
    I_Inner_Bound = W'(ib);
    I_Outer_Bound = W'(ob);
    step();
    I_Start = 1'b0;
    s = cyc;
  endtask

  int s;
  int exp1 [6] = '{0, 1, 2, 256, 257, 258};
  int found;

  initial begin
    reset = 1'b1; I_Start = 1'b0; I_Abort = 1'b0; I_Ready = 1'b1;
    I_Inner_Bound = '0; I_Outer_Bound = '0;
    clear_log();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_valid", O_Valid, 0);
    chk("rst_busy",  O_Busy,  0);
    chk("rst_done",  O_Done,  0);
    chk("rst_inner", O_Inner, 0);
    chk("rst_outer", O_Outer, 0);
    step();

    // 3x2 nest, ready always high.
    rmode = 0; clear_log();
    launch(3, 2, s);
    wait_idle(50);
    chk("t1_beats", cap.size(), 6);
    for (int k = 0; k < 6; k++) chk("t1_seq", (k < cap.size()) ? cap[k] : -1, exp1[k]);
    chk("t1_last_cyc", last_cyc - s, 5);
    chk("t1_done_cyc", done_cyc - s, 6);
    chk("t1_done_cnt", done_cnt, 1);

    // Same nest, ready low every other cycle.
    rmode = 1; clear_log();
    launch(3, 2, s);
    wait_idle(50);
    chk("t2_beats", cap.size(), 6);
    for (int k = 0; k < 6; k++) chk("t2_seq", (k < cap.size()) ? cap[k] : -1, exp1[k]);
    chk("t2_done_lat", (cap_cyc.size() == 6) ? done_cyc - cap_cyc[5] : -1, 1);
    chk("t2_done_cnt", done_cnt, 1);

    // Zero inner bound: no beats, straight to completion.
    rmode = 0; clear_log();
    launch(0, 5, s);
    wait_idle(10);
    chk("t3_beats", cap.size(), 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_done_cyc", done_cyc - s, 0);

    // Abort on beat (1,2) of a 4x4 nest, then restart.
    clear_log();
    launch(4, 4, s);
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      if (O_Valid && O_Outer == 1 && O_Inner == 2) found = 1;
      else step();
    end
    chk("t4_found", found, 1);
    I_Abort = 1'b1;
    step();
    I_Abort = 1'b0;
    chk("t4_valid", O_Valid, 0);
    chk("t4_inner", O_Inner, 0);
    chk("t4_outer", O_Outer, 0);
    chk("t4_busy",  O_Busy,  0);
    step(); step();
    launch(4, 4, s);
    chk("t4_rs_valid", O_Valid, 1);
    chk("t4_rs_idx", {O_Outer, O_Inner}, 0);
    wait_idle(40);
    chk("t4_beats", cap.size(), 7 + 16);
    chk("t4_done_cnt", done_cnt, 1);

    // Single outer iteration, long inner loops.
    clear_log();
    launch(15, 1, s);
    wait_idle(40);
    chk("t5_beats", cap.size(), 15);
    chk("t5_final", (cap.size() == 15) ? cap[14] : -1, 14);
    chk("t5_last_cyc", last_cyc - s, 14);
    chk("t5_done_cyc", done_cyc - s, 15);
    clear_log();
    launch(255, 1, s);
    wait_idle(300);
    chk("t5_max_beats", cap.size(), 255);
    chk("t5_max_final", (cap.size() == 255) ? cap[254] : -1, 254);
    clear_log();
    launch(1, 1, s);
    chk("t5_one_last", O_Last, 1);
    wait_idle(10);
    chk("t5_one_done", done_cyc - s, 1);

    // Mid-run start ignored, then reset on the third beat.
    clear_log();
    launch(3, 3, s);
    step();
    I_Start = 1'b1; I_Inner_Bound = 8'd1; I_Outer_Bound = 8'd1;
    step();
    I_Start = 1'b0;
    chk("t6_beat3_inner", O_Inner, 2);
    chk("t6_beat3_outer", O_Outer, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_valid", O_Valid, 0);
    chk("t6_rst_busy",  O_Busy,  0);
    chk("t6_rst_idx", {O_Outer, O_Inner}, 0);
    step(); step();
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_beats", cap.size(), 2);

    // Randomized traffic: starts, aborts, resets and backpressure.
    rmode = 2;
    for (int k = 0; k < 3000; k++) begin
      reset         = ($urandom % 300) == 0;
      I_Abort       = ($urandom % 50) == 0;
      I_Start       = ($urandom % 6) == 0;
      I_Inner_Bound = W'($urandom % 6);
      I_Outer_Bound = W'($urandom % 4);
      step();
    end
    reset = 1'b0; I_Abort = 1'b0; I_Start = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
